// File: rtl/sha1_pad_if.sv
// sha1_pad_if: byte-stream input and 512-bit block output of the SHA-1 padder.
//   data_in/data_valid/data_last/data_ready : message byte stream (ready/valid)
//   block_out/block_valid/block_last/block_ready : padded block stream (ready/valid)
// Modports:
//   master - upstream byte source and downstream block sink (the padder's environment)
//   slave  - the padder itself
interface sha1_pad_if;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_last;
  logic         data_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;

  modport master (
    output data_in, data_valid, data_last, block_ready,
    input  data_ready, block_out, block_valid, block_last
  );

  modport slave (
    input  data_in, data_valid, data_last, block_ready,
    output data_ready, block_out, block_valid, block_last
  );
endinterface

// File: rtl/sha1_pad.sv
// sha1_pad: SHA-1 message padder feeding the sha1 core.
// Accepts a byte stream, appends 0x80, zero fill and the 64-bit big-endian bit
// length, and emits 512-bit blocks. Word i of block_out is bits [32i+31:32i];
// message byte j of a block lands in word j/4, byte 0 of a word in bits [31:24].
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high
//   bus      - sha1_pad_if.slave (byte input stream, block output stream)
//   overflow - sticky byte-counter wrap flag (only with SHA1_PAD_OVF_EN)
// Parameters:
//   CNT_W    - message byte counter width; bit length = {cnt, 3'b000}
// Optional feature macro: SHA1_PAD_OVF_EN (adds the overflow port).
module sha1_pad #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  sha1_pad_if.slave   bus
`ifdef SHA1_PAD_OVF_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [2:0] {FILL, PAD, ZERO, LENGTH, EMIT} state_t;

  state_t             state_q, state_d;
  state_t             nxt_q, nxt_d;
  logic [5:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [511:0]       blk_q, blk_d;
  logic               last_q, last_d;
  // Low for the first cycle after reset releases so data_ready rises one
  // cycle after reset falls.
  logic               rdy_q;
`ifdef SHA1_PAD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // LSB position of byte slot j: word j/4, big-endian within the word.
  function automatic logic [8:0] slot_lsb(input logic [5:0] j);
    return {j[5:2], 5'b0} + {4'b0, ~j[1:0], 3'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      nxt_q   <= FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SHA1_PAD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      rdy_q   <= 1'b1;
`ifdef SHA1_PAD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    logic [63:0] bitlen;
    state_d = state_q;
    nxt_d   = nxt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    last_d  = last_q;
    bitlen  = 64'({cnt_q, 3'b000});
`ifdef SHA1_PAD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      FILL: begin
        if (rdy_q && bus.data_valid) begin
          blk_d[slot_lsb(ptr_q) +: 8] = bus.data_in;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SHA1_PAD_OVF_EN
          if (cnt_q == '1) ovf_d = 1'b1;
`endif
          if (ptr_q == 6'd63) begin
            ptr_d   = '0;
            last_d  = 1'b0;
            nxt_d   = bus.data_last ? PAD : FILL;
            state_d = EMIT;
          end else begin
            ptr_d = ptr_q + 6'd1;
            if (bus.data_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        // Slots above ptr may hold bytes from an earlier block; clear them.
        for (int unsigned j = 0; j < 64; j++) begin
          if (6'(j) > ptr_q) blk_d[slot_lsb(6'(j)) +: 8] = '0;
        end
        blk_d[slot_lsb(ptr_q) +: 8] = 8'h80;
        if (ptr_q <= 6'd55) begin
          state_d = LENGTH;
        end else begin
          last_d  = 1'b0;
          nxt_d   = ZERO;
          state_d = EMIT;
        end
      end
      ZERO: begin
        blk_d   = '0;
        state_d = LENGTH;
      end
      LENGTH: begin
        blk_d[479:448] = bitlen[63:32];
        blk_d[511:480] = bitlen[31:0];
        last_d  = 1'b1;
        nxt_d   = FILL;
        state_d = EMIT;
      end
      EMIT: begin
        if (bus.block_ready) begin
          state_d = nxt_q;
          ptr_d   = '0;
          if (last_q) begin
            cnt_d  = '0;
            blk_d  = '0;
            last_d = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bus.data_ready  = (state_q == FILL) && rdy_q;
    bus.block_valid = (state_q == EMIT);
    bus.block_last  = last_q;
    bus.block_out   = blk_q;
`ifdef SHA1_PAD_OVF_EN
    overflow        = ovf_q;
`endif
  end

endmodule

// File: tb/tb_sha1_pad.sv
module tb_sha1_pad;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sha1_pad_if bus();
`ifdef SHA1_PAD_OVF_EN
  logic ovf_main, ovf_small;
  sha1_pad_if bus4();
`endif

  sha1_pad #(.CNT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef SHA1_PAD_OVF_EN
    ,
    .overflow (ovf_main)
`endif
  );

`ifdef SHA1_PAD_OVF_EN
  sha1_pad #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus4),
    .overflow (ovf_small)
  );
`endif

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input logic lst);
    int n = 0;
    bus.data_in = b; bus.data_valid = 1'b1; bus.data_last = lst;
    while (!bus.data_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bus.data_ready) begin
      errors++;
      $display("FAIL send_timeout: data_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    bus.data_valid = 1'b0; bus.data_last = 1'b0;
  endtask

  // lat counts negedges from the call until block_valid is seen.
  task automatic get_block(output logic [511:0] blk, output logic lst, output int lat);
    lat = 0;
    while (!bus.block_valid && lat < 300) begin @(negedge clk); lat++; end
    checks++;
    if (!bus.block_valid) begin
      errors++;
      $display("FAIL block_timeout: block_valid=0 after %0d cycles, required 1", lat);
    end
    blk = bus.block_out; lst = bus.block_last;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus.data_ready); end
    checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.block_valid); end
    checks++; if (bus.block_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", bus.block_last); end
    checks++; if (bus.block_out !== 512'd0) begin errors++; $display("FAIL rst_block: got %h expected 0", bus.block_out); end
    reset = 1'b0;
    #1;
    checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL rst_fall_ready: got %b expected 0", bus.data_ready); end
    @(negedge clk);
    checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready: got %b expected 1", bus.data_ready); end
  endtask

  task automatic test_abc();
    logic [511:0] exp, blk; logic lst; int lat;
    exp = '0; exp[31:0] = 32'h61626380; exp[511:480] = 32'h00000018;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    get_block(blk, lst, lat);
    checks++; if (blk !== exp) begin errors++; $display("FAIL abc_block: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL abc_last: got %b expected 1", lst); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL abc_latency: got %0d expected 2", lat); end
    checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL abc_dwell: block_valid got %b expected 0", bus.block_valid); end
  endtask

  task automatic test_boundary_55();
    logic [511:0] exp, blk; logic lst; int lat;
    exp = '0; exp[447:416] = 32'h00000080; exp[511:480] = 32'h000001B8;
    for (int i = 0; i < 55; i++) send_byte(8'h00, i == 54);
    get_block(blk, lst, lat);
    checks++; if (blk !== exp) begin errors++; $display("FAIL b55_block: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL b55_last: got %b expected 1", lst); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b55_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_56();
    logic [511:0] exp, blk; logic lst; int lat;
    for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55);
    get_block(blk, lst, lat);
    exp = '0; exp[479:448] = 32'h80000000;
    checks++; if (blk !== exp) begin errors++; $display("FAIL m56_block1: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b0) begin errors++; $display("FAIL m56_last1: got %b expected 0", lst); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL m56_latency1: got %0d expected 1", lat); end
    get_block(blk, lst, lat);
    exp = '0; exp[511:480] = 32'h000001C0;
    checks++; if (blk !== exp) begin errors++; $display("FAIL m56_block2: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL m56_last2: got %b expected 1", lst); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL m56_latency2: got %0d expected 2", lat); end
  endtask

  task automatic test_64();
    logic [511:0] exp, blk; logic lst; int lat;
    for (int i = 0; i < 64; i++) send_byte(8'hFF, i == 63);
    get_block(blk, lst, lat);
    exp = '1;
    checks++; if (blk !== exp) begin errors++; $display("FAIL m64_block1: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b0) begin errors++; $display("FAIL m64_last1: got %b expected 0", lst); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL m64_latency1: got %0d expected 0", lat); end
    get_block(blk, lst, lat);
    exp = '0; exp[31:0] = 32'h80000000; exp[511:480] = 32'h00000200;
    checks++; if (blk !== exp) begin errors++; $display("FAIL m64_block2: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL m64_last2: got %b expected 1", lst); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL m64_latency2: got %0d expected 2", lat); end
  endtask

  task automatic test_stall();
    logic [511:0] exp, snap, blk; logic lst; int lat;
    bus.block_ready = 1'b0;
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    bus.data_in = 8'hAA; bus.data_valid = 1'b1; bus.data_last = 1'b1;
    snap = bus.block_out;
    for (int w = 0; w < 16; w++)
      exp[32*w +: 32] = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
    checks++; if (snap !== exp) begin errors++; $display("FAIL stall_content: got %h expected %h", snap, exp); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, bus.block_valid); end
      checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", k, bus.data_ready); end
      checks++; if (bus.block_out !== snap) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, bus.block_out, snap); end
      @(negedge clk);
    end
    bus.block_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready: got %b expected 1", bus.data_ready); end
    checks++; if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL stall_resume_valid: got %b expected 0", bus.block_valid); end
    @(negedge clk);
    bus.data_valid = 1'b0; bus.data_last = 1'b0;
    get_block(blk, lst, lat);
    exp = '0; exp[31:0] = 32'hAA800000; exp[511:480] = 32'h00000208;
    checks++; if (blk !== exp) begin errors++; $display("FAIL stall_final_block: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL stall_final_last: got %b expected 1", lst); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp, blk; logic lst; int lat;
    for (int i = 0; i < 20; i++) send_byte(8'h55, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    get_block(blk, lst, lat);
    exp = '0; exp[31:0] = 32'h61626380; exp[511:480] = 32'h00000018;
    checks++; if (blk !== exp) begin errors++; $display("FAIL rstmid_block: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL rstmid_last: got %b expected 1", lst); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp, blk; logic lst; int lat;
    send_byte(8'h61, 1'b0); send_byte(8'h62, 1'b0); send_byte(8'h63, 1'b1);
    get_block(blk, lst, lat);
    checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", bus.data_ready); end
    send_byte(8'h41, 1'b1);
    get_block(blk, lst, lat);
    exp = '0; exp[31:0] = 32'h41800000; exp[511:480] = 32'h00000008;
    checks++; if (blk !== exp) begin errors++; $display("FAIL b2b_block: got %h expected %h", blk, exp); end
    checks++; if (lst !== 1'b1) begin errors++; $display("FAIL b2b_last: got %b expected 1", lst); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
  endtask

`ifdef SHA1_PAD_OVF_EN
  task automatic test_overflow();
    logic [511:0] exp; int n;
    for (int i = 0; i < 20; i++) begin
      bus4.data_in = 8'h11; bus4.data_valid = 1'b1; bus4.data_last = (i == 19);
      n = 0;
      while (!bus4.data_ready && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!bus4.data_ready) begin errors++; $display("FAIL ovf_send_timeout: data_ready=0 at byte %0d", i); end
      @(negedge clk);
      bus4.data_valid = 1'b0; bus4.data_last = 1'b0;
      if (i == 14) begin
        checks++; if (ovf_small !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", ovf_small); end
      end
      if (i == 15) begin
        checks++; if (ovf_small !== 1'b1) begin errors++; $display("FAIL ovf_rise: got %b expected 1", ovf_small); end
      end
    end
    n = 0;
    while (!bus4.block_valid && n < 100) begin @(negedge clk); n++; end
    exp = '0;
    for (int w = 0; w < 5; w++) exp[32*w +: 32] = 32'h11111111;
    exp[191:160] = 32'h80000000; exp[511:480] = 32'h00000020;
    checks++; if (bus4.block_out !== exp) begin errors++; $display("FAIL ovf_block: got %h expected %h", bus4.block_out, exp); end
    checks++; if (bus4.block_last !== 1'b1) begin errors++; $display("FAIL ovf_last: got %b expected 1", bus4.block_last); end
    @(negedge clk);
    checks++; if (ovf_small !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_small); end
    checks++; if (ovf_main !== 1'b0) begin errors++; $display("FAIL ovf_main: got %b expected 0", ovf_main); end
  endtask
`endif

  initial begin
    bus.data_in = '0; bus.data_valid = 1'b0; bus.data_last = 1'b0; bus.block_ready = 1'b1;
`ifdef SHA1_PAD_OVF_EN
    bus4.data_in = '0; bus4.data_valid = 1'b0; bus4.data_last = 1'b0; bus4.block_ready = 1'b1;
`endif
    @(negedge clk);
    test_reset();
    test_abc();
    test_boundary_55();
    test_56();
    test_64();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA1_PAD_OVF_EN
    test_overflow();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
